// File: rtl/vr_hw2_seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one add-and-shift per clock.
// Product {acc,q} is ready M cycles after START is accepted.
module vr_hw2_seq_multiplier #(
  parameter int M = 32
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           START,
  input  logic [M-1:0]   A,
  input  logic [M-1:0]   B,
  output logic           BUSY,
  output logic           DONE,
  output logic [2*M-1:0] P
);

  localparam int CW = $clog2(M+1);
  localparam logic [CW-1:0] LAST = CW'(M-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [M-1:0]  mcand;
  logic [M-1:0]  acc;
  logic [M-1:0]  q;
  logic [CW-1:0] cnt;
  logic [M:0]    add;
  logic          accept;

  // Adder slice: carry lands in add[M] and shifts into acc[M-1]
  assign add = {1'b0, acc}
             + {1'b0, (q[0] ? mcand : {M{1'b0}})};

  assign accept = START
    && (state == S_IDLE || state == S_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (START) state_nx = S_RUN;
      S_RUN:
        if (cnt == LAST) state_nx = S_DONE;
      S_DONE:
        state_nx = START ? S_RUN : S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= S_IDLE;
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mcand <= A;
        q     <= B;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == S_RUN) begin
        {acc, q} <= {add, q[M-1:1]};
        cnt      <= cnt + CW'(1);
      end
    end
  end

  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_DONE);
  assign P    = {acc, q};

endmodule
